relu_grad_apply: RTL and testbench

RELU_GRAD_APPLY -- requirements
Module: relu_grad_apply

---
 rtl/cnn_fp_pkg.sv | 34 +++
 rtl/fp32_mul_pipe.sv | 105 ++++++++++
 rtl/relu_grad_apply.sv | 119 +++++++++++
 tb/tb_relu_grad_apply.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_fp_pkg.sv
// Shared FP32 definitions for the CNN gradient datapath: field layout, special
// encodings and a flush-to-zero operand classifier.
package cnn_fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp32_t;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
   localparam int          FP32_EXP_BIAS = 127;
   localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;

   // Denormals classify as zero: the datapath never sees a subnormal operand.
   function automatic fp_class_e fp_classify(input fp32_t x);
      fp_class_e cls;
      if (x.exp == 8'h00)
         cls = FP_ZERO;
      else if (x.exp == FP32_EXP_MAX)
         cls = (x.mant == 23'h0) ? FP_INF : FP_NAN;
      else
         cls = FP_NORM;
      return cls;
   endfunction

endpackage

// File: rtl/fp32_mul_pipe.sv
// Back half of the FP32 multiply: S2 forms the 24x24 significand product, S3
// normalises, rounds to nearest-even and packs into the registered result.
module fp32_mul_pipe
   import cnn_fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        in_valid,
   input  logic        in_bypass,
   input  logic [31:0] in_bypass_val,
   input  logic        in_sign,
   input  logic [10:0] in_exp,
   input  logic [23:0] in_ma,
   input  logic [23:0] in_mb,
   output logic        out_valid,
   output logic [31:0] out_result
);

   logic               s2_valid_reg;
   logic               s2_bypass_reg;
   logic [31:0]        s2_bypass_val_reg;
   logic               s2_sign_reg;
   logic signed [10:0] s2_exp_reg;
   logic [47:0]        s2_prod_reg;

   logic               out_valid_reg;
   logic [31:0]        out_result_reg;

   logic [22:0]        frac;
   logic               guard;
   logic               sticky;
   logic               round_up;
   logic signed [10:0] exp_norm;
   logic signed [10:0] exp_rnd;
   logic [24:0]        sig_rnd;
   logic [22:0]        frac_rnd;
   logic [31:0]        result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg      <= 1'b0;
         s2_bypass_reg     <= 1'b0;
         s2_bypass_val_reg <= 32'h0;
         s2_sign_reg       <= 1'b0;
         s2_exp_reg        <= 11'sd0;
         s2_prod_reg       <= 48'h0;
      end else if (en) begin
         s2_valid_reg      <= in_valid;
         s2_bypass_reg     <= in_bypass;
         s2_bypass_val_reg <= in_bypass_val;
         s2_sign_reg       <= in_sign;
         s2_exp_reg        <= signed'(in_exp);
         s2_prod_reg       <= 48'(in_ma) * 48'(in_mb);
      end
   end

   // Product of two [1,2) significands lies in [1,4): bit 47 selects the shift.
   always_comb begin
      if (s2_prod_reg[47]) begin
         frac     = s2_prod_reg[46:24];
         guard    = s2_prod_reg[23];
         sticky   = |s2_prod_reg[22:0];
         exp_norm = s2_exp_reg + 11'sd1;
      end else begin
         frac     = s2_prod_reg[45:23];
         guard    = s2_prod_reg[22];
         sticky   = |s2_prod_reg[21:0];
         exp_norm = s2_exp_reg;
      end
      round_up = guard && (sticky || frac[0]);
      sig_rnd  = {1'b0, 1'b1, frac} + 25'(round_up);
      if (sig_rnd[24]) begin
         exp_rnd  = exp_norm + 11'sd1;
         frac_rnd = sig_rnd[23:1];
      end else begin
         exp_rnd  = exp_norm;
         frac_rnd = sig_rnd[22:0];
      end

      if (s2_bypass_reg)
         result = s2_bypass_val_reg;
      else if (exp_rnd >= 11'sd255)
         result = {s2_sign_reg, FP32_EXP_MAX, 23'h0};
      else if (exp_rnd <= 11'sd0)
         result = {s2_sign_reg, 31'h0};
      else
         result = {s2_sign_reg, exp_rnd[7:0], frac_rnd};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg  <= 1'b0;
         out_result_reg <= 32'h0;
      end else if (en) begin
         out_valid_reg <= s2_valid_reg;
         if (s2_valid_reg)
            out_result_reg <= result;
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_result = out_result_reg;

endmodule

// File: rtl/relu_grad_apply.sv
// Leaky-ReLU backward pass: passes top_diff where the forward input was positive,
// otherwise scales it by NEGATIVE_SLOPE through a 3-stage FP32 multiply pipeline.
module relu_grad_apply
   import cnn_fp_pkg::*;
#(
   parameter logic [31:0] NEGATIVE_SLOPE = 32'h38D1B717
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] bottom_data,
   input  logic [31:0] top_diff,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_diff
);

   fp32_t       bottom;
   fp_class_e   bottom_class;
   logic        bottom_pos;
   fp32_t       op [2];
   fp_class_e   op_class [2];
   logic [23:0] op_sig [2];
   logic        any_nan, any_inf, any_zero, zero_times_inf;
   logic        advance;

   logic        prod_sign_next;
   logic        bypass_next;
   logic [31:0] bypass_val_next;
   logic [10:0] exp_sum_next;

   logic        s1_valid_reg;
   logic        s1_bypass_reg;
   logic [31:0] s1_bypass_val_reg;
   logic        s1_sign_reg;
   logic [10:0] s1_exp_reg;
   logic [23:0] s1_ma_reg;
   logic [23:0] s1_mb_reg;

   assign bottom       = fp32_t'(bottom_data);
   assign bottom_class = fp_classify(bottom);
   assign bottom_pos   = !bottom.sign && (bottom_class == FP_NORM || bottom_class == FP_INF);

   // Operand 0 is the gradient, operand 1 the constant slope.
   assign op[0] = fp32_t'(top_diff);
   assign op[1] = fp32_t'(NEGATIVE_SLOPE);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_op
         assign op_class[gi] = fp_classify(op[gi]);
         assign op_sig[gi]   = {1'b1, op[gi].mant};
      end
   endgenerate

   assign any_nan        = (op_class[0] == FP_NAN)  || (op_class[1] == FP_NAN);
   assign any_inf        = (op_class[0] == FP_INF)  || (op_class[1] == FP_INF);
   assign any_zero       = (op_class[0] == FP_ZERO) || (op_class[1] == FP_ZERO);
   assign zero_times_inf = any_inf && any_zero;

   // Pass-through and every special-case product are resolved here and ride the
   // pipeline as a bypass value; only finite nonzero products use the multiplier.
   always_comb begin
      prod_sign_next  = op[0].sign ^ op[1].sign;
      bypass_next     = 1'b1;
      bypass_val_next = top_diff;
      exp_sum_next    = {3'b000, op[0].exp} + {3'b000, op[1].exp} - 11'(FP32_EXP_BIAS);
      if (!bottom_pos) begin
         if (any_nan || zero_times_inf)
            bypass_val_next = FP32_QNAN;
         else if (any_inf)
            bypass_val_next = {prod_sign_next, FP32_EXP_MAX, 23'h0};
         else if (any_zero)
            bypass_val_next = {prod_sign_next, 31'h0};
         else
            bypass_next = 1'b0;
      end
   end

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_reg      <= 1'b0;
         s1_bypass_reg     <= 1'b0;
         s1_bypass_val_reg <= 32'h0;
         s1_sign_reg       <= 1'b0;
         s1_exp_reg        <= 11'h0;
         s1_ma_reg         <= 24'h0;
         s1_mb_reg         <= 24'h0;
      end else if (advance) begin
         s1_valid_reg      <= in_valid;
         s1_bypass_reg     <= bypass_next;
         s1_bypass_val_reg <= bypass_val_next;
         s1_sign_reg       <= prod_sign_next;
         s1_exp_reg        <= exp_sum_next;
         s1_ma_reg         <= op_sig[0];
         s1_mb_reg         <= op_sig[1];
      end
   end

   fp32_mul_pipe u_mul (
      .clk           (clk),
      .rst_n         (reset),
      .en            (advance),
      .in_valid      (s1_valid_reg),
      .in_bypass     (s1_bypass_reg),
      .in_bypass_val (s1_bypass_val_reg),
      .in_sign       (s1_sign_reg),
      .in_exp        (s1_exp_reg),
      .in_ma         (s1_ma_reg),
      .in_mb         (s1_mb_reg),
      .out_valid     (out_valid),
      .out_result    (out_diff)
   );

endmodule

// File: tb/tb_relu_grad_apply.sv
// Scoreboard bench for relu_grad_apply: two instances (slope 0.5 and 1.5) share
// stimulus; a negedge monitor pops hand-computed expectations per output.
`timescale 1ns/1ps
module tb_relu_grad_apply;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] bottom_data = 32'h0;
   logic [31:0] top_diff = 32'h0;
   logic        in_ready_h, in_ready_r, out_valid_h, out_valid_r;
   logic [31:0] out_diff_h, out_diff_r;

   relu_grad_apply #(.NEGATIVE_SLOPE(32'h3F000000)) dut_half (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_h),
      .bottom_data(bottom_data), .top_diff(top_diff), .out_valid(out_valid_h),
      .out_ready(out_ready), .out_diff(out_diff_h)
   );

   relu_grad_apply #(.NEGATIVE_SLOPE(32'h3FC00000)) dut_1p5 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
      .bottom_data(bottom_data), .top_diff(top_diff), .out_valid(out_valid_r),
      .out_ready(out_ready), .out_diff(out_diff_r)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] b;
      logic [31:0] t;
      logic [31:0] eh;
      logic [31:0] er;
   } vec_t;

   typedef struct packed {
      logic [31:0] eh;
      logic [31:0] er;
      int          tx_cyc;
      logic        chk_lat;
   } exp_t;

   vec_t vecs [$];
   exp_t sb [$];
   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   n_out = 0;

   // Transfer edge loads S1; out_valid is up after the second edge that follows.
   localparam int LAT_EDGES = 2;

   always @(posedge clk) cyc++;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic add_vec(input logic [31:0] b, input logic [31:0] t,
                          input logic [31:0] eh, input logic [31:0] er);
      vec_t v;
      v.b = b; v.t = t; v.eh = eh; v.er = er;
      vecs.push_back(v);
   endtask

   // Call at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input vec_t v, input logic chk_lat);
      int   waited = 0;
      logic done = 1'b0;
      exp_t e;
      in_valid = 1'b1; bottom_data = v.b; top_diff = v.t;
      while (!done) begin
         @(negedge clk);
         if (in_ready_h) begin
            e.eh = v.eh; e.er = v.er; e.tx_cyc = cyc + 1; e.chk_lat = chk_lat;
            sb.push_back(e);
            done = 1'b1;
         end else if (++waited > 100) begin
            checks++; fails++;
            $display("FAIL accept_timeout: in_ready still 0, required 1 within 100 cycles");
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      check32("drain_queue_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: inputs only change at posedge+1, so negedge sees the handshake
   // values that the next rising edge will act on.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_h = 32'h0, prev_r = 32'h0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check32("stall_valid_held", {31'h0, out_valid_h}, 32'd1);
            check32("stall_hold_half", out_diff_h, prev_h);
            check32("stall_hold_1p5", out_diff_r, prev_r);
         end
         if (out_valid_h && out_ready) begin
            if (sb.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_output: got %08h, required no output", out_diff_h);
            end else begin
               e = sb.pop_front();
               n_out++;
               $display("out %0d @cyc %0d: half=%08h (exp %08h) 1p5=%08h (exp %08h)",
                        n_out, cyc, out_diff_h, e.eh, out_diff_r, e.er);
               check32("data_half", out_diff_h, e.eh);
               check32("data_1p5", out_diff_r, e.er);
               check32("valid_1p5", {31'h0, out_valid_r}, 32'd1);
               if (e.chk_lat)
                  check32("latency_edges", 32'(cyc - e.tx_cyc), 32'(LAT_EDGES));
            end
         end
         prev_stall = out_valid_h && !out_ready;
         prev_h = out_diff_h;
         prev_r = out_diff_r;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, sb=%0d pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      //       bottom        top           x0.5          x1.5
      add_vec(32'h3F800000, 32'h40400000, 32'h40400000, 32'h40400000);
      add_vec(32'hBF800000, 32'h40800000, 32'h40000000, 32'h40C00000);
      add_vec(32'h00000000, 32'hC0C00000, 32'hC0400000, 32'hC1100000);
      add_vec(32'hBF800000, 32'h7FC00001, 32'h7FC00000, 32'h7FC00000);
      add_vec(32'hBF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000);
      add_vec(32'hBF800000, 32'h80800000, 32'h80000000, 32'h80C00000);
      add_vec(32'h80000000, 32'h3F800000, 32'h3F000000, 32'h3FC00000);
      add_vec(32'h00000001, 32'h40000000, 32'h3F800000, 32'h40400000);
      add_vec(32'h7FC00000, 32'h40000000, 32'h3F800000, 32'h40400000);
      add_vec(32'h7F800000, 32'h7FC00123, 32'h7FC00123, 32'h7FC00123);
      add_vec(32'h3F800000, 32'h00000001, 32'h00000001, 32'h00000001);
      add_vec(32'hBF800000, 32'h00000001, 32'h00000000, 32'h00000000);
      add_vec(32'hBF800000, 32'h7F7FFFFF, 32'h7EFFFFFF, 32'h7F800000);
      add_vec(32'hBF800000, 32'h80000000, 32'h80000000, 32'h80000000);
      add_vec(32'hBF800000, 32'h3F800001, 32'h3F000001, 32'h3FC00002);
      add_vec(32'hBF800000, 32'h3F800003, 32'h3F000003, 32'h3FC00004);
      add_vec(32'hC0000000, 32'h00800000, 32'h00000000, 32'h00C00000);
      add_vec(32'h40000000, 32'hFF800000, 32'hFF800000, 32'hFF800000);

      repeat (3) @(posedge clk);
      #1;
      check32("reset_out_valid", {31'h0, out_valid_h}, 32'd0);
      check32("reset_out_diff", out_diff_h, 32'h0);
      check32("reset_in_ready", {31'h0, in_ready_h}, 32'd1);
      check32("reset_in_ready_1p5", {31'h0, in_ready_r}, 32'd1);
      reset = 1'b1;

      // First pair right after release, then every vector back to back.
      for (int i = 0; i < vecs.size(); i++)
         send(vecs[i], 1'b1);
      drain();

      // Eight pairs streamed into a stalled output.
      fork
         begin
            for (int i = 1; i <= 8; i++)
               send(vecs[i], 1'b0);
         end
         begin
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            check32("bp_in_ready_low", {31'h0, in_ready_h}, 32'd0);
            check32("bp_out_valid", {31'h0, out_valid_h}, 32'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two pairs in flight; neither may ever emerge.
      send(vecs[1], 1'b0);
      send(vecs[2], 1'b0);
      reset = 1'b0;
      #1;
      check32("midreset_out_valid", {31'h0, out_valid_h}, 32'd0);
      check32("midreset_out_diff", out_diff_h, 32'h0);
      check32("midreset_out_diff_1p5", out_diff_r, 32'h0);
      check32("midreset_in_ready", {31'h0, in_ready_h}, 32'd1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      send(vecs[3], 1'b1);
      drain();
      check32("total_outputs", 32'(n_out), 32'(vecs.size() + 8 + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
